// File: rtl/mobo_mem_ctrl_pkg.sv
// Shared definitions for the motherboard memory controller: request/status bit
// positions on the cpu bus and controller state codes (the cpu side uses the same).
package mobo_mem_ctrl_pkg;

  localparam int CTRL_RD   = 0;
  localparam int CTRL_WR   = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } mobo_state_e;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with registered read data (1-cycle read latency).
module ram_sp #(
  parameter int width = 32,
  parameter int depth = 256,
  parameter int aw    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    addr,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/mobo_mem_ctrl.sv
// Memory controller behind the cpu bus port: 4-phase req/done handshake, one
// transaction at a time, programmable wait states before each RAM access.
module mobo_mem_ctrl
  import mobo_mem_ctrl_pkg::*;
#(
  parameter int word_width  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  output logic [word_width-1:0] mobo_stat,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] data_wr,
  output logic [word_width-1:0] data_rd
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(WAIT_STATES + 2);
  localparam logic [CW-1:0] WLAST = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mobo_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [word_width-1:0] addr_q, addr_d;
  logic [word_width-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic [word_width-1:0] data_rd_q, data_rd_d;

  logic                  rd_req, wr_req, in_range, ram_we;
  logic [AW-1:0]         ram_addr;
  logic [word_width-1:0] ram_dout;
  logic                  unused_ctrl;

  assign rd_req      = mobo_ctrl[CTRL_RD];
  assign wr_req      = mobo_ctrl[CTRL_WR];
  assign unused_ctrl = ^mobo_ctrl[word_width-1:2];
  assign in_range    = (addr_q < word_width'(MEM_WORDS));

  // In IDLE the RAM is pointed at the live bus address so read data is already
  // registered by the time XFER runs, even with zero wait states.
  assign ram_addr = (state_q == ST_IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];
  assign ram_we   = (state_q == ST_XFER) && wr_q && in_range;

  ram_sp #(.width(word_width), .depth(MEM_WORDS), .aw(AW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    data_rd_d = data_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req ^ wr_req) begin
          addr_d  = addr;
          data_d  = data_wr;
          wr_d    = wr_req;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
        end else if (rd_req && wr_req) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WLAST) state_d = ST_XFER;
        else                cnt_d   = cnt_q + 1'b1;
      end
      ST_XFER: begin
        if (!in_range) begin
          state_d = ST_ERR;
        end else begin
          if (!wr_q) data_rd_d = ram_dout;
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (!(rd_req || wr_req)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      data_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      data_rd_q <= data_rd_d;
    end
  end

  always_comb begin
    mobo_stat            = '0;
    mobo_stat[STAT_BUSY] = (state_q == ST_WAIT) || (state_q == ST_XFER);
    mobo_stat[STAT_DONE] = (state_q == ST_DONE);
    mobo_stat[STAT_ERR]  = (state_q == ST_ERR);
  end

  assign data_rd = data_rd_q;

endmodule
